// File: rtl/game_pkg.sv
// Shared types and constants for the game sequencer.
// State encoding doubles as the banner renderer's game_state code.
package game_pkg;

    typedef enum logic [2:0] {
        TITLE = 3'd0,
        LOAD  = 3'd1,
        PLAY  = 3'd2,
        CLEAR = 3'd3,
        OVER  = 3'd4
    } game_state_e;

    localparam logic [6:0] SCORE_MAX = 7'd99;

    // Sum is formed on 8 bits so 99+99 cannot wrap before clamping.
    function automatic logic [6:0] sat_add(
        input logic [6:0] a,
        input logic [6:0] b
    );
        logic [7:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : sum[6:0];
    endfunction

endpackage

// File: rtl/frame_timer.sv
// Banner frame counter: counts enabled ticks, saturates at LIMIT.
// Flags the LIMIT-th tick and the saturated condition.
module frame_timer #(
    parameter int LIMIT = 120
) (
    input  logic Clk,
    input  logic reset_h,
    input  logic clear,
    input  logic enable,
    input  logic tick,
    output logic last_tick,
    output logic done
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] count;

    always_ff @(posedge Clk) begin
        if (reset_h || clear) begin
            count <= '0;
        end else if (enable && tick && !done) begin
            count <= count + W'(1);
        end
    end

    assign done      = (count == W'(LIMIT));
    assign last_tick = tick && (count == W'(LIMIT - 1));

endmodule

// File: rtl/game_sequencer.sv
// Top-level game flow: title, level load, play, banners and game over.
// Tracks level, lives, banked score and the victory flag.
module game_sequencer
    import game_pkg::*;
#(
    parameter int BANNER_FRAMES = 120,
    parameter int MAX_LEVEL     = 3,
    parameter int START_LIVES   = 3
) (
    input  logic       Clk,
    input  logic       reset_h,
    input  logic       shoot,
    input  logic       VGA_VS,
    input  logic       is_won,
    input  logic       is_lost,
    input  logic [6:0] level_score,
    output logic       level_reset,
    output logic [1:0] level_num,
    output logic [2:0] game_state,
    output logic [1:0] lives,
    output logic [6:0] score,
    output logic       victory
);

    localparam logic [1:0] LAST_LVL  = 2'(MAX_LEVEL - 1);
    localparam logic [1:0] LIVES_INI = 2'(START_LIVES);

    game_state_e state, state_n;
    logic [6:0]  bank, bank_n;
    logic [1:0]  lives_n;
    logic [1:0]  lvl_n;
    logic        vic_n;
    logic [6:0]  score_n;

    logic vs_q;
    logic shoot_q;
    logic frame_tick;
    logic start_evt;
    logic last_tick;
    logic banner_done;
    logic tmr_clear;
    logic tmr_enable;

    assign frame_tick = vs_q & ~VGA_VS;
    assign start_evt  = shoot & ~shoot_q;

    // Any state change restarts the banner count.
    assign tmr_clear  = (state_n != state);
    assign tmr_enable = (state == CLEAR) || (state == OVER);

    frame_timer #(
        .LIMIT(BANNER_FRAMES)
    ) u_frame_timer (
        .Clk      (Clk),
        .reset_h  (reset_h),
        .clear    (tmr_clear),
        .enable   (tmr_enable),
        .tick     (frame_tick),
        .last_tick(last_tick),
        .done     (banner_done)
    );

    always_comb begin
        state_n = state;
        bank_n  = bank;
        lives_n = lives;
        lvl_n   = level_num;
        vic_n   = victory;
        unique case (state)
            TITLE: begin
                if (start_evt) begin
                    lvl_n   = 2'd0;
                    bank_n  = 7'd0;
                    vic_n   = 1'b0;
                    lives_n = LIVES_INI;
                    state_n = LOAD;
                end
            end
            LOAD: begin
                state_n = PLAY;
            end
            PLAY: begin
                if (is_won) begin
                    bank_n  = sat_add(bank, level_score);
                    state_n = CLEAR;
                end else if (is_lost) begin
                    lives_n = lives - 2'd1;
                    if (lives == 2'd1) begin
                        vic_n   = 1'b0;
                        state_n = OVER;
                    end else begin
                        state_n = LOAD;
                    end
                end
            end
            CLEAR: begin
                if (last_tick) begin
                    if (level_num == LAST_LVL) begin
                        vic_n   = 1'b1;
                        state_n = OVER;
                    end else begin
                        lvl_n   = level_num + 2'd1;
                        state_n = LOAD;
                    end
                end
            end
            OVER: begin
                if (start_evt && banner_done) begin
                    state_n = TITLE;
                end
            end
            default: begin
                state_n = TITLE;
            end
        endcase
    end

    // Live score shows the running attempt on top of the bank while playing.
    assign score_n = (state_n == PLAY) ? sat_add(bank_n, level_score) : bank_n;

    always_ff @(posedge Clk) begin
        if (reset_h) begin
            state       <= TITLE;
            bank        <= 7'd0;
            lives       <= 2'd0;
            level_num   <= 2'd0;
            victory     <= 1'b0;
            score       <= 7'd0;
            level_reset <= 1'b1;
            vs_q        <= 1'b1;
            shoot_q     <= 1'b0;
        end else begin
            state       <= state_n;
            bank        <= bank_n;
            lives       <= lives_n;
            level_num   <= lvl_n;
            victory     <= vic_n;
            score       <= score_n;
            level_reset <= (state_n != PLAY);
            vs_q        <= VGA_VS;
            shoot_q     <= shoot;
        end
    end

    assign game_state = state;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed scenarios plus random play,
// checked each cycle against a behavioural model of the game rules.
module tb_game_sequencer;

    localparam int BF = 120;
    localparam int ML = 3;
    localparam int SL = 3;

    logic       Clk = 1'b0;
    logic       reset_h = 1'b1;
    logic       shoot = 1'b0;
    logic       VGA_VS = 1'b1;
    logic       is_won = 1'b0;
    logic       is_lost = 1'b0;
    logic [6:0] level_score = 7'd0;
    logic       level_reset;
    logic [1:0] level_num;
    logic [2:0] game_state;
    logic [1:0] lives;
    logic [6:0] score;
    logic       victory;

    int errors = 0;
    int checks = 0;
    bit cmp_on = 1'b0;
    bit rnd_vs = 1'b0;
    int vs_cnt = 0;

    int m_state, m_lvl, m_lives, m_bank, m_score, m_vic, m_frames, m_lrst;
    bit m_pvs, m_psh;

    game_sequencer #(
        .BANNER_FRAMES(BF),
        .MAX_LEVEL    (ML),
        .START_LIVES  (SL)
    ) dut (
        .Clk        (Clk),
        .reset_h    (reset_h),
        .shoot      (shoot),
        .VGA_VS     (VGA_VS),
        .is_won     (is_won),
        .is_lost    (is_lost),
        .level_score(level_score),
        .level_reset(level_reset),
        .level_num  (level_num),
        .game_state (game_state),
        .lives      (lives),
        .score      (score),
        .victory    (victory)
    );

    always #10 Clk = ~Clk;

    function automatic int sat(input int x);
        return (x > 99) ? 99 : x;
    endfunction

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t",
                         name, act, exp, $time);
        end
    endtask

    // Game rules: 0=title 1=load 2=play 3=clear 4=over.
    always @(posedge Clk) begin : model
        int s, l, lv, b, v, f;
        bit tick, start;
        if (reset_h) begin
            m_state  <= 0;
            m_lvl    <= 0;
            m_lives  <= 0;
            m_bank   <= 0;
            m_vic    <= 0;
            m_frames <= 0;
            m_score  <= 0;
            m_lrst   <= 1;
            m_pvs    <= 1'b1;
            m_psh    <= 1'b0;
        end else begin
            s = m_state; l = m_lvl; lv = m_lives;
            b = m_bank;  v = m_vic; f = m_frames;
            tick  = m_pvs && !VGA_VS;
            start = shoot && !m_psh;
            if (s == 0) begin
                if (start) begin
                    l = 0; b = 0; v = 0; lv = SL; s = 1;
                end
            end else if (s == 1) begin
                s = 2;
            end else if (s == 2) begin
                if (is_won) begin
                    b = sat(b + int'(level_score));
                    f = 0;
                    s = 3;
                end else if (is_lost) begin
                    lv = lv - 1;
                    if (lv == 0) begin
                        s = 4; v = 0; f = 0;
                    end else begin
                        s = 1;
                    end
                end
            end else if (s == 3) begin
                if (tick) begin
                    f++;
                    if (f == BF) begin
                        f = 0;
                        if (l == ML - 1) begin
                            s = 4; v = 1;
                        end else begin
                            l++; s = 1;
                        end
                    end
                end
            end else begin
                if (start && f >= BF) s = 0;
                else if (tick && f < BF) f++;
            end
            m_state  <= s;
            m_lvl    <= l;
            m_lives  <= lv;
            m_bank   <= b;
            m_vic    <= v;
            m_frames <= f;
            m_score  <= (s == 2) ? sat(b + int'(level_score)) : b;
            m_lrst   <= (s != 2) ? 1 : 0;
            m_pvs    <= VGA_VS;
            m_psh    <= shoot;
        end
    end

    always @(negedge Clk) begin
        if (cmp_on) begin
            cmp("game_state", game_state, m_state);
            cmp("level_num", level_num, m_lvl);
            cmp("lives", lives, m_lives);
            cmp("score", score, m_score);
            cmp("victory", victory, m_vic);
            cmp("level_reset", level_reset, m_lrst);
        end
    end

    task automatic step();
        if (vs_cnt == 0) begin
            VGA_VS = 1'b0;
            vs_cnt = rnd_vs ? $urandom_range(1, 5) : 4;
        end else begin
            VGA_VS = 1'b1;
            vs_cnt--;
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic wait_state(input string name, input int exp, input int bound);
        int k;
        k = 0;
        while (game_state != 3'(exp) && k < bound) begin
            step();
            k++;
        end
        cmp(name, game_state, exp);
    endtask

    initial begin
        run(2);
        cmp_on  = 1'b1;
        reset_h = 1'b0;
        cmp("rst_state", game_state, 0);
        cmp("rst_lives", lives, 0);
        cmp("rst_lrst", level_reset, 1);
        cmp("rst_score", score, 0);

        shoot = 1'b1;
        step();
        cmp("load", game_state, 1);
        cmp("load_lrst", level_reset, 1);
        step();
        shoot = 1'b0;
        cmp("play", game_state, 2);
        cmp("play_lrst", level_reset, 0);
        cmp("play_lives", lives, 3);
        cmp("play_lvl", level_num, 0);

        level_score = 7'd40;
        step();
        cmp("play_score", score, 40);
        is_won = 1'b1;
        step();
        is_won = 1'b0;
        level_score = 7'd0;
        cmp("clear", game_state, 3);
        cmp("clear_score", score, 40);
        run(BF * 5 - 20);
        cmp("clear_hold", game_state, 3);
        wait_state("clear_to_load", 1, 200);
        cmp("lvl1", level_num, 1);
        step();

        level_score = 7'd50;
        step();
        is_won = 1'b1;
        step();
        is_won = 1'b0;
        cmp("bank90", score, 90);
        wait_state("load2", 1, BF * 6 + 20);
        step();
        cmp("play2", game_state, 2);
        cmp("lvl2", level_num, 2);
        level_score = 7'd25;
        step();
        cmp("sat99", score, 99);

        is_won  = 1'b1;
        is_lost = 1'b1;
        step();
        is_won  = 1'b0;
        is_lost = 1'b0;
        cmp("both_clear", game_state, 3);
        cmp("both_lives", lives, 3);
        cmp("both_score", score, 99);
        wait_state("vict_over", 4, BF * 6 + 20);
        cmp("victory", victory, 1);

        run(BF * 5 + 20);
        shoot = 1'b1;
        step();
        cmp("title", game_state, 0);
        shoot = 1'b0;
        step();
        shoot = 1'b1;
        run(2);
        shoot = 1'b0;
        level_score = 7'd7;
        for (int i = 0; i < 2; i++) begin
            is_lost = 1'b1;
            step();
            is_lost = 1'b0;
            cmp("lost_load", game_state, 1);
            cmp("lost_lives", lives, 2 - i);
            step();
        end
        is_lost = 1'b1;
        step();
        is_lost = 1'b0;
        cmp("lost_over", game_state, 4);
        cmp("lost_vic", victory, 0);
        cmp("lost_lives0", lives, 0);
        cmp("lost_score", score, 0);
        step();
        shoot = 1'b1;
        step();
        shoot = 1'b0;
        step();
        cmp("early_ignored", game_state, 4);
        run(BF * 5 + 20);
        shoot = 1'b1;
        step();
        cmp("late_title", game_state, 0);
        shoot = 1'b0;
        step();

        shoot = 1'b1;
        run(2);
        shoot = 1'b0;
        level_score = 7'd10;
        is_won = 1'b1;
        step();
        is_won = 1'b0;
        cmp("mid_clear", game_state, 3);
        run(60 * 5);
        reset_h = 1'b1;
        step();
        reset_h = 1'b0;
        cmp("mid_rst_state", game_state, 0);
        cmp("mid_rst_lives", lives, 0);
        cmp("mid_rst_score", score, 0);
        cmp("mid_rst_lvl", level_num, 0);
        cmp("mid_rst_vic", victory, 0);
        cmp("mid_rst_lrst", level_reset, 1);

        rnd_vs = 1'b1;
        for (int i = 0; i < 40000; i++) begin
            is_won  = ($urandom_range(0, 59) == 0);
            is_lost = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 5) == 0) shoot = ~shoot;
            if ($urandom_range(0, 15) == 0)
                level_score = 7'($urandom_range(0, 99));
            reset_h = ($urandom_range(0, 7999) == 0);
            step();
        end
        reset_h = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
